// File: rtl/trivium_controller_pkg.sv
// Shared constants and types for the Trivium sequencer and its keystream packer.
package trivium_pkg;

  localparam int LEN_A         = 93;
  localparam int LEN_B         = 84;
  localparam int LEN_C         = 111;
  localparam int WARMUP_CYCLES = 1152;
  localparam int WCNT_W        = $clog2(WARMUP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARMUP,
    ST_RUN
  } trivium_state_t;

  // Register C starts with its three top bits set and everything else clear.
  function automatic logic [LEN_C-1:0] c_init_value();
    return {3'b111, {(LEN_C-3){1'b0}}};
  endfunction

endpackage

// File: rtl/trivium_controller_if.sv
// Keystream word handshake between the controller (master) and its consumer (slave).
interface trivium_controller_if #(
  parameter int OUT_WIDTH = 8
);

  logic [OUT_WIDTH-1:0] ks_data;
  logic                 ks_valid;
  logic                 ks_ready;

  modport master (output ks_data, output ks_valid, input ks_ready);
  modport slave  (input ks_data, input ks_valid, output ks_ready);

endinterface

// File: rtl/trivium_controller_packer.sv
// keystream_packer: serial z_bit collector, shift issue throttling and output word register.
// Optional accepted-word counter enabled by TRIVIUM_CTRL_KS_COUNT_EN.
module keystream_packer #(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 run_i,
  input  logic                 z_bit_i,
  output logic                 issue_o,
`ifdef TRIVIUM_CTRL_KS_COUNT_EN
  output logic [31:0]          ks_count_o,
`endif
  trivium_controller_if.master ks
);

  localparam int CW = $clog2(OUT_WIDTH + 1);
  localparam int IW = $clog2(OUT_WIDTH);
  localparam logic [CW-1:0] FULL = CW'(OUT_WIDTH);

  logic [OUT_WIDTH-1:0] coll_q, coll_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [OUT_WIDTH-1:0] word;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        iss_q, iss_d;
  logic                 cap_q, cap_d;
  logic                 vld_q, vld_d;
  logic                 full, last, word_rdy, accept, xfer, issue;

  // A word is complete either already in the collector or with the bit arriving now.
  always_comb begin
    full     = (cnt_q == FULL);
    last     = cap_q && (cnt_q == FULL - CW'(1));
    word_rdy = full || last;
    accept   = vld_q && ks.ks_ready;
    xfer     = word_rdy && (!vld_q || ks.ks_ready);
    // Issuing past a full word is only allowed when the output register is empty, so
    // the stream stays gap-free without a combinational path from ks_ready to shift_o.
    issue    = run_i && ((iss_q != FULL) || (word_rdy && !vld_q));
    word     = coll_q;
    if (!full) word[OUT_WIDTH-1] = z_bit_i;
  end

  always_comb begin
    coll_d = coll_q;
    cnt_d  = cnt_q;
    iss_d  = iss_q;
    data_d = data_q;
    vld_d  = vld_q;
    cap_d  = issue && !clr_i;
    if (accept) vld_d = 1'b0;
    if (cap_q && !full) begin
      coll_d[cnt_q[IW-1:0]] = z_bit_i;
      cnt_d                 = cnt_q + CW'(1);
    end
    if (xfer) begin
      data_d = word;
      vld_d  = 1'b1;
      cnt_d  = '0;
      iss_d  = CW'(issue);
    end else if (issue) begin
      iss_d = iss_q + CW'(1);
    end
    if (clr_i) begin
      coll_d = '0;
      cnt_d  = '0;
      iss_d  = '0;
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      iss_q  <= '0;
      cap_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      coll_q <= coll_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      iss_q  <= iss_d;
      cap_q  <= cap_d;
      vld_q  <= vld_d;
    end
  end

`ifdef TRIVIUM_CTRL_KS_COUNT_EN
  logic [31:0] kcnt_q, kcnt_d;

  always_comb begin
    kcnt_d = kcnt_q;
    if (clr_i) kcnt_d = '0;
    else if (accept && (kcnt_q != '1)) kcnt_d = kcnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kcnt_q <= '0;
    else        kcnt_q <= kcnt_d;
  end

  assign ks_count_o = kcnt_q;
`endif

  assign issue_o     = issue;
  assign ks.ks_data  = data_q;
  assign ks.ks_valid = vld_q;

endmodule

// File: rtl/trivium_controller.sv
// Trivium sequencer: key/IV load, 1152-shift warm-up, then byte-packed keystream.
// TRIVIUM_CTRL_KS_COUNT_EN adds the saturating ks_count output.
module trivium_controller
  import trivium_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int IV_WIDTH  = 80,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [IV_WIDTH-1:0]  iv,
  output logic                 busy,
  output logic                 load_o,
  output logic                 shift_o,
  output logic [LEN_A-1:0]     din_a,
  output logic [LEN_B-1:0]     din_b,
  output logic [LEN_C-1:0]     din_c,
  input  logic                 z_bit,
`ifdef TRIVIUM_CTRL_KS_COUNT_EN
  output logic [31:0]          ks_count,
`endif
  trivium_controller_if.master ks
);

  trivium_state_t       state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [KEY_WIDTH-1:0] key_q;
  logic [IV_WIDTH-1:0]  iv_q;
  logic                 cinit_q;
  logic                 take;
  logic                 ks_issue;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start) begin
          take    = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_WARMUP;
        wcnt_d  = '0;
      end
      ST_WARMUP: begin
        if (wcnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      key_q   <= '0;
      iv_q    <= '0;
      cinit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (take) begin
        key_q   <= key;
        iv_q    <= iv;
        cinit_q <= 1'b1;
      end
    end
  end

  assign busy    = (state_q == ST_LOAD) || (state_q == ST_WARMUP);
  assign load_o  = (state_q == ST_LOAD);
  assign shift_o = (state_q == ST_WARMUP) || ks_issue;
  assign din_a   = {{(LEN_A-KEY_WIDTH){1'b0}}, key_q};
  assign din_b   = {{(LEN_B-IV_WIDTH){1'b0}}, iv_q};
  assign din_c   = cinit_q ? c_init_value() : '0;

  // A restart from RUN clears the packer in the start cycle, dropping the in-flight bit.
  keystream_packer #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (take),
    .run_i      (state_q == ST_RUN),
    .z_bit_i    (z_bit),
    .issue_o    (ks_issue),
`ifdef TRIVIUM_CTRL_KS_COUNT_EN
    .ks_count_o (ks_count),
`endif
    .ks         (ks)
  );

endmodule
